// File: rtl/mem_sram16.sv
// ---------------------------------------------------------------------------
// mem_sram16
//
// Purpose
//   Behavioural single-port SRAM (2**ADDR_W words of DATA_W bits, 128K x 16 by
//   default) with independent byte lanes on one bidirectional data bus. It is
//   the memory under test behind the BIST controller.
//
//   Writes and read-data capture happen on the rising edge of clk. The bus is
//   driven combinationally from the registered read word, so read data is on
//   io one clock after the address and controls are applied. It stays there
//   as long as a, oe and cs are held.
//
// Ports
//   clk    in     1             single clock, rising-edge active
//   rst_n  in     1             asynchronous, active-low reset
//   a      in     ADDR_W        word address (every value is a valid location)
//   oe     in     1             output enable / read request, active high
//   cs     in     DATA_W/8      per-lane chip select, active high (cs[i] -> io[8i+7:8i])
//   we     in     DATA_W/8      per-lane write enable, active high
//   io     inout  DATA_W        bidirectional data bus
//
// Bus handshake (one rule for every lane i, evaluated each cycle)
//   cs[i]=0                 : lane idle. It is not written and not driven.
//   cs[i]=1, we[i]=1        : lane written from io at the rising edge. The DUT
//                             never drives a lane that is being written.
//   cs[i]=1, we[i]=0, oe=1  : lane driven with rd_q, the word captured at the
//                             previous edge.
//   Otherwise, and whenever rst_n=0, the lane is hi-Z.
// ---------------------------------------------------------------------------
module mem_sram16 #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     a,
    input  logic                  oe,
    input  logic [DATA_W/8-1:0]   cs,
    input  logic [DATA_W/8-1:0]   we,
    inout  wire  [DATA_W-1:0]     io
);

    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    // Storage. It has no reset, so contents survive rst_n. Locations that
    // were never written read back as X in a four-state simulator.
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Registered read word. rd_d is sampled from the array before this
    // edge's write lands, which gives read-before-write behaviour.
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    // Per-lane qualifiers.
    logic [LANES-1:0] wr_lane_en;
    logic [LANES-1:0] rd_lane_en;

    assign rd_d = mem[a];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        // Write needs this lane's chip select and write enable; oe plays no part.
        assign wr_lane_en[g] = cs[g] & we[g];

        // A lane being written is never driven, so a write never contends
        // with read data. rst_n gates the drive so the bus floats for the
        // whole reset period.
        assign rd_lane_en[g] = rst_n & oe & cs[g] & ~we[g];

        assign io[8*g +: 8] = rd_lane_en[g] ? rd_q[8*g +: 8] : 8'bz;
    end

    // Array write. Lanes are written independently, and no write happens
    // while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lane_en[i]) begin
                    mem[a][8*i +: 8] <= io[8*i +: 8];
                end
            end
        end
    end

    // Read capture on every edge. It clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

endmodule

// File: tb/tb_mem_sram16.sv
// ---------------------------------------------------------------------------
// tb_mem_sram16
//
// Directed bench for mem_sram16. The bench drives each bus lane through its
// own enable. To check that the DUT leaves a lane floating, the bench drives
// that lane with 8'h00 while the DUT is expected to be idle. If the DUT also
// drives the lane, the resolved value either changes or goes to X.
// ---------------------------------------------------------------------------
module tb_mem_sram16;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [ADDR_W-1:0] a;
    logic              oe;
    logic [1:0]        cs;
    logic [1:0]        we;
    wire  [DATA_W-1:0] io;

    // Bench-side bus driver, one enable per lane.
    logic [1:0]        tb_en;
    logic [DATA_W-1:0] tb_drv;

    assign io[7:0]  = tb_en[0] ? tb_drv[7:0]  : 8'bz;
    assign io[15:8] = tb_en[1] ? tb_drv[15:8] : 8'bz;

    mem_sram16 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .oe    (oe),
        .cs    (cs),
        .we    (we),
        .io    (io)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: io=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Queue the hand-computed expected bus value, then compare it with io.
    task automatic expect_io(input logic [DATA_W-1:0] exp, input string tag);
        exp_q.push_back(exp);
        check_eq(tag, io, exp_q.pop_front());
    endtask

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic set_ctl(input logic [ADDR_W-1:0] addr, input logic o,
                           input logic [1:0] c, input logic [1:0] w);
        a  = addr;
        oe = o;
        cs = c;
        we = w;
    endtask

    task automatic set_bus(input logic [1:0] en, input logic [DATA_W-1:0] d);
        tb_en  = en;
        tb_drv = d;
    endtask

    // Guard against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus. Inputs change on the falling edge, and io is sampled on the
    // falling edge (or 1ns after an asynchronous change).
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        set_ctl('0, 1'b0, 2'b00, 2'b00);
        set_bus(2'b00, '0);
        repeat (3) @(negedge clk);

        // Reset: the bus floats even with a read requested.
        set_ctl('0, 1'b1, 2'b11, 2'b00);
        set_bus(2'b11, 16'h0000);
        #1 expect_io(16'h0000, "rst_hiz");
        // Release reset. Before any edge, rd_q is still 0 and is now driven.
        set_bus(2'b00, '0);
        rst_n = 1'b1;
        #1 expect_io(16'h0000, "rst_rdq_zero");

        // 1. Full-word write at a=1. The bus must carry only the bench's data.
        @(negedge clk);
        set_ctl(17'd1, 1'b0, 2'b11, 2'b11);
        set_bus(2'b11, 16'h0113);
        repeat (2) @(negedge clk);
        expect_io(16'h0113, "t1_wr_no_drive");

        // 2. Low-byte write, then high-byte write, at a=0.
        set_ctl(17'd0, 1'b0, 2'b01, 2'b01);
        set_bus(2'b01, 16'h0031);
        @(negedge clk);
        set_ctl(17'd0, 1'b0, 2'b10, 2'b10);
        set_bus(2'b10, 16'h2100);
        @(negedge clk);

        // 3. Full-word read at a=0, checked again while the inputs are held.
        set_ctl(17'd0, 1'b1, 2'b11, 2'b00);
        set_bus(2'b00, '0);
        @(negedge clk);
        expect_io(16'h2131, "t3_word_read");
        @(negedge clk);
        expect_io(16'h2131, "t3_word_hold");

        // 4. Byte reads at a=1. The bench drives 8'h00 on the unselected lane.
        set_ctl(17'd1, 1'b1, 2'b01, 2'b00);
        set_bus(2'b10, 16'h0000);
        @(negedge clk);
        expect_io(16'h0013, "t4_lo_byte");
        set_ctl(17'd1, 1'b1, 2'b10, 2'b00);
        set_bus(2'b01, 16'h0000);
        @(negedge clk);
        expect_io(16'h0100, "t4_hi_byte");

        // 5. Idle cases. rd_q keeps holding mem[1]=0113, so any stray drive
        // would show up on the bus.
        set_ctl(17'd1, 1'b0, 2'b11, 2'b00);
        set_bus(2'b11, 16'h0000);
        @(negedge clk);
        expect_io(16'h0000, "t5_oe_low");
        set_ctl(17'd1, 1'b1, 2'b00, 2'b00);
        @(negedge clk);
        expect_io(16'h0000, "t5_cs_off");
        // Write with oe=1. The DUT must stay off the bus.
        set_ctl(17'd1, 1'b1, 2'b11, 2'b11);
        set_bus(2'b11, 16'h4440);
        @(negedge clk);
        expect_io(16'h4440, "t5_wr_oe_no_drive");
        // Read-before-write: the capture at the write edge returned the old data.
        set_ctl(17'd1, 1'b1, 2'b11, 2'b00);
        set_bus(2'b00, '0);
        #1 expect_io(16'h0113, "t5_rbw_old");
        @(negedge clk);
        expect_io(16'h4440, "t5_rbw_new");

        // A lane with cs=0 is not written, even with we=1.
        set_ctl(17'd3, 1'b0, 2'b11, 2'b11);
        set_bus(2'b11, 16'hA5A5);
        @(negedge clk);
        set_ctl(17'd3, 1'b0, 2'b01, 2'b11);
        set_bus(2'b11, 16'h5A5A);
        @(negedge clk);
        set_ctl(17'd3, 1'b1, 2'b11, 2'b00);
        set_bus(2'b00, '0);
        @(negedge clk);
        expect_io(16'hA55A, "cs_gates_write");

        // 6. Reset asserted during a read of a=0.
        set_ctl(17'd0, 1'b1, 2'b11, 2'b00);
        @(negedge clk);
        expect_io(16'h2131, "t6_pre_reset");
        #2;
        rst_n = 1'b0;
        set_bus(2'b11, 16'h0000);
        #1 expect_io(16'h0000, "t6_rst_hiz");
        // This write is attempted while reset is held and must not land.
        set_ctl(17'd0, 1'b0, 2'b11, 2'b11);
        set_bus(2'b11, 16'hFFFF);
        repeat (2) @(negedge clk);
        set_ctl(17'd0, 1'b1, 2'b11, 2'b00);
        set_bus(2'b00, '0);
        rst_n = 1'b1;
        #1 expect_io(16'h0000, "t6_rdq_cleared");
        @(negedge clk);
        expect_io(16'h2131, "t6_contents_kept");

        // Lane independence: the low lane is written while the high lane reads.
        set_ctl(17'd0, 1'b1, 2'b11, 2'b01);
        set_bus(2'b01, 16'h007E);
        @(negedge clk);
        expect_io(16'h217E, "mix_lo_wr_hi_rd");
        set_ctl(17'd0, 1'b1, 2'b11, 2'b00);
        set_bus(2'b00, '0);
        @(negedge clk);
        expect_io(16'h217E, "mix_readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
